nibble_parity_checker: RTL and testbench
========================================

# nibble_parity_checker

Serial frame receiver and parity checker that sits directly upstream of the team's combinational four-input XOR stage. It deserialises 5-bit frames (4 data bits MSB-first, then 1 parity bit) from a valid/ready bit stream and recomputes the 4-input XOR parity over the nibble. It presents the nibble and a pass/fail flag on a one-entry valid/ready output register, and it keeps saturating frame and error counters.

## Interface
- ODD_PARITY, 0: 0 = even parity (expected parity bit = a[3]^a[2]^a[1]^a[0]); 1 = odd parity (expected = inverse of that XOR).
- CNT_W, 16: width of the frame and error counters.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  reset, synchronous, active-low.
- clr  input  1  synchronous clear: discards the partial frame and zeroes the counters. Does not affect the held output.
- in_bit  input  1  serial data or parity bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  checker accepts in_bit this cycle.
- out_nibble  output  4  received data nibble {a3,a2,a1,a0}.
- out_parity  output  1  received parity bit.
- out_ok  output  1  1 = received parity equals computed parity.
- out_valid  output  1  output register holds a frame.
- out_ready  input  1  consumer takes the frame.
- frame_count  output  CNT_W  completed frames, saturating.
- err_count  output  CNT_W  frames with out_ok=0, saturating.

## Operation
- A bit is accepted when in_valid && in_ready.
- bit_idx (0..4) counts accepted bits in the current frame.
  - idx 0..3 shift into the nibble MSB-first: the first bit becomes a[3].
  - idx 4 is the parity bit.
- State COLLECT (idx 0..3):
  - in_ready=1 unconditionally.
  - Bits can be collected while a previous frame is still held at the output.
- State PARITY (idx 4):
  - in_ready = !out_valid || out_ready.
  - On acceptance:
    - the output register loads the nibble, the parity bit, and ok = (parity == (^nibble ^ ODD_PARITY));
    - out_valid is set;
    - bit_idx returns to 0;
    - counters update.
- Output handshake:
  - out_valid holds until out_valid && out_ready.
  - out_* data is stable while out_valid=1 && out_ready=0.
  - If out_ready and a new parity-bit acceptance occur in the same cycle, the new frame is loaded and out_valid stays 1.
- Counters:
  - frame_count increments on each completed frame.
  - err_count increments when the computed ok=0.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (reset=0 at a clock edge):
  - bit_idx=0, out_valid=0, out_nibble=0, out_parity=0, out_ok=0, counters=0;
  - in_ready reads 1 on the first cycle after reset.
- Latency: out_valid rises on the edge that accepts the parity bit, so it is visible 1 cycle after that bit is presented.
- Throughput: 1 frame per 5 accepted bits. There are no bubbles when the consumer keeps out_ready=1.
- clr:
  - At a clock edge, clr=1 forces bit_idx=0 and zeroes frame_count and err_count.
  - An in_bit accepted in the same cycle is discarded.
  - clr has priority over counter increments.
  - out_valid and the held frame are unaffected.
- Reset mid-frame drops the partial frame and the held output with no further output.
- in_ready is combinational from out_valid, out_ready and bit_idx. No other input-to-output combinational paths exist.

## Configuration
- NIBBLE_PARITY_CNT_EN defined: frame_count and err_count are implemented as described.
- NIBBLE_PARITY_CNT_EN not defined:
  - the counter registers are not built;
  - frame_count and err_count are tied to 0;
  - the ports remain;
  - clr still clears the partial frame.

## Test plan
- Even parity: send bits 1,0,1,1 then parity 1.
  - Required: out_nibble=4'b1011, out_parity=1, out_ok=1, frame_count=1, err_count=0.
- Parity error: send 0,1,1,0 then parity 1.
  - Required: out_ok=0, err_count=1.
  - With ODD_PARITY=1, the same frame gives out_ok=1.
- Backpressure: hold out_ready=0 and stream two frames.
  - Required: frame 1 stays stable on the outputs.
  - in_ready=1 for bits 0..3 of frame 2 and drops to 0 at its parity bit.
  - Raising out_ready for one cycle loads frame 2 in that cycle, and out_valid stays 1.
- Exhaustive: all 16 nibbles × both parity values, back-to-back with out_ready=1.
  - Required: out_ok matches the XOR each time, frame_count=32, err_count=16.
- clr and reset mid-frame:
  - clr after 2 bits: the next 5 bits form a clean frame, and the counters restart from 0.
  - reset=0 after 3 bits: out_valid=0 and all outputs return to their reset values.
- Saturation: with CNT_W=4, send 20 bad frames.
  - Required: err_count=15 and frame_count=15.

Source files
------------

// File: rtl/nibble_parity_checker.sv
// nibble_parity_checker: deserialises 5-bit frames (4 data bits MSB-first,
// then 1 parity bit) from a valid/ready bit stream. It checks the parity
// against the XOR of the nibble and holds the result in a one-entry
// valid/ready output register.
// Optional feature macro: NIBBLE_PARITY_CNT_EN builds the saturating frame
// and error counters. When the macro is undefined, both counter ports read 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer must not retract valid before the transfer. Data is stable
// while valid is high and ready is low. ready may depend combinationally on
// the consumer's ready, which is the case for in_ready here.
module nibble_parity_checker #(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_nibble,
  output logic             out_parity,
  output logic             out_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] PARITY_IDX = 3'd4;

  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] shift_q, shift_d;
  logic [3:0] out_nibble_q, out_nibble_d;
  logic       out_parity_q, out_parity_d;
  logic       out_ok_q, out_ok_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;
  logic       ok_bit;

  // A data bit is always accepted. The parity bit waits until the output
  // register is empty or is being drained in this same cycle.
  assign in_ready = (bit_idx_q != PARITY_IDX) || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign ok_bit   = (in_bit == (^shift_q ^ ODD_PARITY));

  // Next-state for frame collection and the output register.
  always_comb begin
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    out_nibble_d = out_nibble_q;
    out_parity_d = out_parity_q;
    out_ok_d     = out_ok_q;
    out_valid_d  = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (clr) begin
      bit_idx_d = 3'd0;
      shift_d   = 4'd0;
    end else if (accept) begin
      if (bit_idx_q == PARITY_IDX) begin
        out_nibble_d = shift_q;
        out_parity_d = in_bit;
        out_ok_d     = ok_bit;
        out_valid_d  = 1'b1;
        bit_idx_d    = 3'd0;
      end else begin
        shift_d   = {shift_q[2:0], in_bit};
        bit_idx_d = bit_idx_q + 3'd1;
      end
    end
  end

  // Registers for frame collection and the output holding register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_idx_q    <= 3'd0;
      shift_q      <= 4'd0;
      out_nibble_q <= 4'd0;
      out_parity_q <= 1'b0;
      out_ok_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      out_nibble_q <= out_nibble_d;
      out_parity_q <= out_parity_d;
      out_ok_q     <= out_ok_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_nibble = out_nibble_q;
  assign out_parity = out_parity_q;
  assign out_ok     = out_ok_q;
  assign out_valid  = out_valid_q;

`ifdef NIBBLE_PARITY_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             frame_done;

  assign frame_done = accept && !clr && (bit_idx_q == PARITY_IDX);

  // Saturating counters. clr wins over any increment in the same cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else if (frame_done) begin
      if (!(&frame_cnt_q)) frame_cnt_d = frame_cnt_q + CNT_ONE;
      if (!ok_bit && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_nibble_parity_checker.sv
// Testbench for nibble_parity_checker. An even-parity instance and an
// odd-parity instance share every input. A reference model built from
// queues of accepted bits predicts each frame and the counter values.
module tb_nibble_parity_checker;

  localparam int CNT_W = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef NIBBLE_PARITY_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk, reset, clr, in_bit, in_valid, out_ready;
  logic in_ready, out_parity, out_ok, out_valid;
  logic [3:0] out_nibble;
  logic [CNT_W-1:0] frame_count, err_count;
  logic o_in_ready, o_out_parity, o_out_ok, o_out_valid;
  logic [3:0] o_out_nibble;
  logic [CNT_W-1:0] o_frame_count, o_err_count;

  nibble_parity_checker #(.ODD_PARITY(1'b0), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_nibble(out_nibble), .out_parity(out_parity),
    .out_ok(out_ok), .out_valid(out_valid), .out_ready(out_ready),
    .frame_count(frame_count), .err_count(err_count)
  );

  nibble_parity_checker #(.ODD_PARITY(1'b1), .CNT_W(CNT_W)) u_odd (
    .clk(clk), .reset(reset), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(o_in_ready), .out_nibble(o_out_nibble), .out_parity(o_out_parity),
    .out_ok(o_out_ok), .out_valid(o_out_valid), .out_ready(out_ready),
    .frame_count(o_frame_count), .err_count(o_err_count)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];   // {nibble, parity, ok_even, ok_odd}
  logic       bits_q[$];
  int         m_frames = 0;
  int         m_errs = 0;
  bit         rnd_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects five accepted bits, then predicts the frame.
  task automatic model_bit(input logic b);
    logic [3:0] nib;
    int ones;
    logic par, ok_e, ok_o;
    bits_q.push_back(b);
    if (bits_q.size() == 5) begin
      nib = 4'd0;
      ones = 0;
      for (int i = 0; i < 4; i++) begin
        nib = nib * 2 + 4'(bits_q[i]);
        ones += int'(bits_q[i]);
      end
      par  = bits_q[4];
      ok_e = (int'(par) == (ones % 2));
      ok_o = (int'(par) == 1 - (ones % 2));
      exp_q.push_back({nib, par, ok_e, ok_o});
      if (CNT_ON) begin
        if (m_frames < CNT_MAX) m_frames++;
        if (!ok_e && m_errs < CNT_MAX) m_errs++;
      end
      bits_q.delete();
    end
  endtask

  // Driver tasks. Each is entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int chk_rdy);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_bit = b;
    while (!acc) begin
      @(negedge clk);
      if (n == 0 && chk_rdy >= 0) check("in_ready_collect", 32'(in_ready), 32'(chk_rdy));
      if (in_ready) begin
        acc = 1'b1;
        model_bit(b);
      end
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_bit_timeout: in_ready stuck at 0, required 1");
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] nib, input logic par);
    logic [3:0] t;
    t = nib;
    for (int i = 3; i >= 0; i--) send_bit(t[i], -1);
    send_bit(par, -1);
  endtask

  task automatic clear_cmd();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    bits_q.delete();
    m_frames = 0;
    m_errs = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    clr = 1'b0;
    idle(2);
    reset = 1'b1;
    exp_q.delete();
    bits_q.delete();
    m_frames = 0;
    m_errs = 0;
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_frame_count"}, 32'(frame_count), 32'(m_frames));
    check({tag, "_err_count"}, 32'(err_count), 32'(m_errs));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_nibble"}, 32'(out_nibble), 0);
    check({tag, "_out_parity"}, 32'(out_parity), 0);
    check({tag, "_out_ok"}, 32'(out_ok), 0);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected frames on output transfers and checks hold stability.
  logic       prev_stall = 1'b0;
  logic [5:0] prev_out;
  always @(negedge clk) begin
    logic [6:0] e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'({out_nibble, out_parity, out_ok}), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got nibble %0h with empty expected queue", out_nibble);
        end else begin
          e = exp_q.pop_front();
          check("out_nibble", 32'(out_nibble), 32'(e[6:3]));
          check("out_parity", 32'(out_parity), 32'(e[2]));
          check("out_ok_even", 32'(out_ok), 32'(e[1]));
          check("out_ok_odd", 32'(o_out_ok), 32'(e[0]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {out_nibble, out_parity, out_ok};
    end
  end

  // Main stimulus.
  initial begin
    reset = 1'b0;
    clr = 1'b0;
    in_bit = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_reset_state("reset");

    // Even parity example frame.
    send_frame(4'b1011, 1'b1);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_nibble", 32'(out_nibble), 32'hb);
    check("t1_ok", 32'(out_ok), 1);
    @(posedge clk);
    #1;
    check_counts("t1");

    // Parity error frame; the odd-parity instance sees it as good.
    clear_cmd();
    send_frame(4'b0110, 1'b1);
    @(negedge clk);
    check("t2_ok_even", 32'(out_ok), 0);
    check("t2_ok_odd", 32'(o_out_ok), 1);
    @(posedge clk);
    #1;
    check_counts("t2");

    // Backpressure: two frames with out_ready held low.
    clear_cmd();
    out_ready = 1'b0;
    send_frame(4'b1100, 1'b0);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(negedge clk);
    check("bp_in_ready_parity", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_drain", 32'(in_ready), 1);
    if (in_ready) model_bit(1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid_kept", 32'(out_valid), 1);
    check("bp_frame2_nibble", 32'(out_nibble), 32'h7);
    @(posedge clk);
    #1;
    idle(3);
    out_ready = 1'b1;
    idle(2);
    check_counts("bp");

    // Exhaustive nibbles and parity values, back to back.
    clear_cmd();
    for (int n = 0; n < 16; n++)
      for (int p = 0; p < 2; p++) send_frame(4'(n), 1'(p));
    idle(2);
    check_counts("exh");

    // clr after two bits, then a clean frame.
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    clear_cmd();
    send_frame(4'b0011, 1'b0);
    idle(1);
    check_counts("clr");

    // Reset with a held frame and a partial frame in flight.
    out_ready = 1'b0;
    send_frame(4'b1001, 1'b1);
    send_bit(1'b1, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    do_reset();
    check_reset_state("midreset");
    out_ready = 1'b1;

    // Randomised frames with random gaps and random consumer backpressure.
    rnd_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          for (int b = 0; b < 5; b++) begin
            send_bit(1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 2));
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(3);
    check_counts("rand");

    // Saturation with bad frames.
    clear_cmd();
    for (int f = 0; f < CNT_MAX + 8; f++) begin
      logic [3:0] nb;
      nb = 4'($urandom_range(0, 15));
      send_frame(nb, ~(^nb));
    end
    idle(2);
    check_counts("sat");

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
